inv_shift_rows: RTL and testbench
=================================

INV_SHIFT_ROWS -- requirements
Module: inv_shift_rows

Interface
REQ-001 Parameter: OUT_REG, default 1, meaning 1 = registered output stage and 0 = purely combinational path (data and handshake passed straight through).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: in_valid  input  1  in_data is valid this cycle.
REQ-006 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port: in_data  input  128  AES state, byte k = in_data[127-8k -: 8], column-major (state[r][c] = byte r+4c).
REQ-008 Port: out_valid  output  1  out_data is valid.
REQ-009 Port: out_ready  input  1  downstream accepts out_data.
REQ-010 Port: out_data  output  128  permuted state, same byte mapping as in_data.

Function
REQ-011 The block SHALL implement AES InvShiftRows: for each row r (0..3), out[r][(c+r) mod 4] = in[r][c], i.e. row r rotated right by r byte positions; row 0 is unchanged.
REQ-012 The permutation SHALL be bit-exact byte moves with no arithmetic and no byte-value change.
REQ-013 A transfer SHALL occur on an interface when valid and ready are both high at a rising clk edge.
REQ-014 OUT_REG=1: in_ready = !out_valid || out_ready; an accepted word appears on out_data with out_valid high on the next cycle (latency 1).
REQ-015 OUT_REG=1: out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-016 OUT_REG=1: an output transfer and an input acceptance in the same cycle SHALL replace the register contents with no bubble, giving full throughput of one word per cycle.
REQ-017 OUT_REG=1: out_valid SHALL drop after an output transfer when no new input is accepted in that cycle.
REQ-018 OUT_REG=0: out_data = perm(in_data), out_valid = in_valid, in_ready = out_ready, all combinational; rst has no effect.

Reset
REQ-019 When rst is high, out_valid SHALL be 0 and out_data SHALL be 128'h0 immediately, independent of clk.
REQ-020 When rst is high, in_ready SHALL be 1.
REQ-021 A word held in the register when rst asserts SHALL be discarded.
REQ-022 The first acceptance SHALL be possible on the first clk edge after rst deasserts.

Configuration
REQ-023 The preprocessor macro INV_SHIFT_ROWS_FWD_EN SHALL, when defined, add input port fwd (1 bit) that is sampled with in_data.
REQ-024 With INV_SHIFT_ROWS_FWD_EN defined: fwd=1 selects forward ShiftRows, out[r][c] = in[r][(c+r) mod 4], and fwd=0 selects InvShiftRows.
REQ-025 Without INV_SHIFT_ROWS_FWD_EN: port fwd SHALL be absent and the block SHALL perform InvShiftRows only.

Structure
REQ-026 The shared package aes_pkg SHALL hold the state typedef (4x4 array of 8-bit bytes), constants NB=4 and BYTE_W=8, and the pack/unpack functions between the 128-bit vector and the array.
REQ-027 The permutation SHALL live in one combinational sub-module, shift_rows_perm (inputs: state, dir; output: state); inv_shift_rows SHALL contain only the register stage and handshake logic.

Verification
REQ-028 Reset: assert rst mid-stream -> out_valid=0, out_data=0, in_ready=1 without waiting for a clk edge.
REQ-029 Known vector: in_data=128'hD4BF5D30E0B452AEB84111F11E2798E5, in_valid=1, out_ready=1 -> one cycle later out_data=128'hD42711AEE0BF98F1B8B45DE51E415230 with out_valid=1.
REQ-030 Row 0 invariance: in_data=128'h00112233445566778899AABBCCDDEEFF -> out_data bytes 0,4,8,12 remain 00,44,88,CC.
REQ-031 Backpressure: hold out_ready=0 for 3 cycles with a word registered -> out_data stable, in_ready=0; release -> the word transfers and the next input is accepted in the same cycle.
REQ-032 Streaming: 100 random words with out_ready=1 -> one output per cycle, each matching the reference model; also InvShiftRows(ShiftRows(x)) = x.
REQ-033 With INV_SHIFT_ROWS_FWD_EN: fwd=1, in_data=128'hD42711AEE0BF98F1B8B45DE51E415230 -> out_data=128'hD4BF5D30E0B452AEB84111F11E2798E5.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES state definitions: byte/state typedefs, direction enum and
// conversions between the 128-bit bus vector and the 4x4 state array.
// Byte k of the vector is vec[127-8k -: 8] and maps to state[k % 4][k / 4].
package aes_pkg;

  localparam int unsigned NB      = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STATE_W = NB * NB * BYTE_W;
  localparam int unsigned IDX_W   = $clog2(NB);

  // state[r][c] is one byte, row-major indexing over a column-major bus
  typedef logic [NB-1:0][NB-1:0][BYTE_W-1:0] state_t;

  typedef enum logic {
    DIR_INV = 1'b0,
    DIR_FWD = 1'b1
  } dir_t;

  // 128-bit bus vector -> state array
  function automatic state_t unpack_state(logic [STATE_W-1:0] vec);
    state_t s;
    s = '0;
    for (int unsigned k = 0; k < NB * NB; k++) begin
      s[IDX_W'(k % NB)][IDX_W'(k / NB)] = BYTE_W'(vec >> (BYTE_W * (NB * NB - 1 - k)));
    end
    return s;
  endfunction

  // state array -> 128-bit bus vector, byte 0 in the top bits
  function automatic logic [STATE_W-1:0] pack_state(state_t s);
    logic [STATE_W-1:0] vec;
    vec = '0;
    for (int unsigned k = 0; k < NB * NB; k++) begin
      vec = {vec[STATE_W-BYTE_W-1:0], s[IDX_W'(k % NB)][IDX_W'(k / NB)]};
    end
    return vec;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational AES row rotation.
// Ports:
//   state  - input state array
//   dir    - DIR_INV: out[r][(c+r)%4] = in[r][c]; DIR_FWD: out[r][c] = in[r][(c+r)%4]
//   result - permuted state array (pure byte moves)
module shift_rows_perm
  import aes_pkg::*;
(
  input  state_t state,
  input  dir_t   dir,
  output state_t result
);

  logic [IDX_W-1:0] src;

  // Column arithmetic wraps mod 4 through truncation to IDX_W bits
  always_comb begin
    result = '0;
    src    = '0;
    for (int unsigned r = 0; r < NB; r++) begin
      for (int unsigned c = 0; c < NB; c++) begin
        src = (dir == DIR_FWD) ? IDX_W'(c + r) : IDX_W'(c - r);
        result[IDX_W'(r)][IDX_W'(c)] = state[IDX_W'(r)][src];
      end
    end
  end

endmodule

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows with valid/ready handshake and optional output register.
// Parameter OUT_REG: 1 = registered output (latency 1, full throughput),
//                    0 = combinational pass-through (rst unused).
// Macro INV_SHIFT_ROWS_FWD_EN: adds port fwd; fwd=1 selects forward ShiftRows.
// Ports:
//   clk, rst            - clock, async active-high reset
//   in_valid/in_ready   - input handshake, in_data 128-bit AES state
//   out_valid/out_ready - output handshake, out_data 128-bit permuted state
//   fwd (optional)      - direction select, sampled with in_data
module inv_shift_rows
  import aes_pkg::*;
#(
  parameter int unsigned OUT_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
`ifdef INV_SHIFT_ROWS_FWD_EN
  ,
  input  logic               fwd
`endif
);

  dir_t               dir;
  state_t             perm_state;
  logic [STATE_W-1:0] perm_data;

`ifdef INV_SHIFT_ROWS_FWD_EN
  assign dir = fwd ? DIR_FWD : DIR_INV;
`else
  assign dir = DIR_INV;
`endif

  shift_rows_perm u_perm (
    .state  (unpack_state(in_data)),
    .dir    (dir),
    .result (perm_state)
  );

  assign perm_data = pack_state(perm_state);

  if (OUT_REG != 0) begin : g_reg
    logic               valid_q;
    logic [STATE_W-1:0] data_q;

    // Register may load whenever it is empty or being drained this cycle
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (in_ready) begin
        valid_q <= in_valid;
        if (in_valid) begin
          data_q <= perm_data;
        end
      end
    end
  end else begin : g_comb
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = perm_data;
  end

endmodule

// File: tb/tb_inv_shift_rows.sv
// Self-checking bench for inv_shift_rows (OUT_REG=1) against a byte-level
// reference model of (Inv)ShiftRows. Optional fwd coverage under
// INV_SHIFT_ROWS_FWD_EN.
module tb_inv_shift_rows;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef INV_SHIFT_ROWS_FWD_EN
  logic         fwd;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inv_shift_rows #(.OUT_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef INV_SHIFT_ROWS_FWD_EN
    ,
    .fwd       (fwd)
`endif
  );

  // Reference: byte k = state[k%4][k/4]; inverse moves in[r][c] to out[r][(c+r)%4]
  function automatic logic [127:0] model(logic [127:0] x, bit fwd_dir);
    logic [7:0]   b [16];
    logic [7:0]   o [16];
    logic [127:0] y;
    for (int k = 0; k < 16; k++) b[k] = 8'(x >> (8 * (15 - k)));
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!fwd_dir) o[r + 4 * ((c + r) % 4)] = b[r + 4 * c];
        else          o[r + 4 * c] = b[r + 4 * ((c + r) % 4)];
      end
    end
    y = '0;
    for (int k = 0; k < 16; k++) y = {y[119:0], o[k]};
    return y;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // First edge after reset release accepts the known vector
  task automatic test_known_vector();
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL known_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 128'hD42711AEE0BF98F1B8B45DE51E415230) begin
      errors++; $display("FAIL known_data got %h want D42711AEE0BF98F1B8B45DE51E415230", out_data);
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got %b want 0", out_valid); end
  endtask

  task automatic test_row0();
    logic [127:0] o;
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = 128'h00112233445566778899AABBCCDDEEFF;
    step();
    in_valid = 1'b0;
    o = out_data;
    checks++; if ({o[127:120], o[95:88], o[63:56], o[31:24]} !== 32'h004488CC) begin
      errors++; $display("FAIL row0_bytes got %h want 004488CC", {o[127:120], o[95:88], o[63:56], o[31:24]});
    end
    checks++; if (o !== model(128'h00112233445566778899AABBCCDDEEFF, 1'b0)) begin
      errors++; $display("FAIL row0_full got %h want %h", o, model(128'h00112233445566778899AABBCCDDEEFF, 1'b0));
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b;
    a = rand128(); b = rand128();
    in_valid = 1'b1; out_ready = 1'b0; in_data = a;
    step();
    in_data = b;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== model(a, 1'b0)) begin
        errors++; $display("FAIL bp_hold%0d got v=%b %h want v=1 %h", i, out_valid, out_data, model(a, 1'b0));
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b want 0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== model(b, 1'b0)) begin
      errors++; $display("FAIL bp_next got v=%b %h want v=1 %h", out_valid, out_data, model(b, 1'b0));
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [127:0] q[$];
    logic [127:0] exp_d;
    int sent = 0, got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 150 && got < 100; cyc++) begin
      if (sent < 100) begin in_valid = 1'b1; in_data = rand128(); end
      else in_valid = 1'b0;
      #1;
      if (cyc >= 1 && cyc <= 100) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_gap cyc %0d got %b want 1", cyc, out_valid); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra cyc %0d got %h want none", cyc, out_data);
        end else begin
          exp_d = q.pop_front();
          if (out_data !== exp_d) begin errors++; $display("FAIL stream_data cyc %0d got %h want %h", cyc, out_data, exp_d); end
        end
        got++;
      end
      if (in_valid && in_ready) begin q.push_back(model(in_data, 1'b0)); sent++; end
      step();
    end
    in_valid = 1'b0;
    checks++; if (got != 100) begin errors++; $display("FAIL stream_count got %0d want 100", got); end
  endtask

  // Random valid/ready with scoreboard and hold-stability check
  task automatic test_back_to_back();
    logic [127:0] q[$];
    logic [127:0] exp_d, prev_d;
    logic         stall;
    stall = 1'b0; prev_d = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid  = (cyc < 280) && ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      in_data   = rand128();
      #1;
      if (stall) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev_d) begin
          errors++; $display("FAIL hold cyc %0d got v=%b %h want v=1 %h", cyc, out_valid, out_data, prev_d);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra cyc %0d got %h want none", cyc, out_data);
        end else begin
          exp_d = q.pop_front();
          if (out_data !== exp_d) begin errors++; $display("FAIL b2b_data cyc %0d got %h want %h", cyc, out_data, exp_d); end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_data, 1'b0));
      stall  = out_valid && !out_ready;
      prev_d = out_data;
      step();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_tail got %h want none", out_data); end
        else begin
          exp_d = q.pop_front();
          if (out_data !== exp_d) begin errors++; $display("FAIL b2b_tail got %h want %h", out_data, exp_d); end
        end
      end
      step();
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_left got %0d want 0", q.size()); end
  endtask

  // InvShiftRows(ShiftRows(x)) = x
  task automatic test_roundtrip();
    logic [127:0] x;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      x = rand128();
      in_valid = 1'b1; in_data = model(x, 1'b1);
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== x) begin
        errors++; $display("FAIL roundtrip%0d got v=%b %h want v=1 %h", i, out_valid, out_data, x);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0; in_data = rand128();
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL mid_rst_data got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_discard got %b want 0", out_valid); end
  endtask

`ifdef INV_SHIFT_ROWS_FWD_EN
  task automatic test_fwd();
    logic [127:0] x;
    out_ready = 1'b1; in_valid = 1'b1; fwd = 1'b1;
    in_data = 128'hD42711AEE0BF98F1B8B45DE51E415230;
    step();
    checks++; if (out_data !== 128'hD4BF5D30E0B452AEB84111F11E2798E5) begin
      errors++; $display("FAIL fwd_known got %h want D4BF5D30E0B452AEB84111F11E2798E5", out_data);
    end
    x = rand128(); in_data = x;
    step();
    checks++; if (out_data !== model(x, 1'b1)) begin errors++; $display("FAIL fwd_rand got %h want %h", out_data, model(x, 1'b1)); end
    fwd = 1'b0; in_valid = 1'b0;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef INV_SHIFT_ROWS_FWD_EN
    fwd = 1'b0;
`endif
    test_reset();
    test_known_vector();
    test_row0();
    test_backpressure();
    test_streaming();
    test_back_to_back();
    test_roundtrip();
`ifdef INV_SHIFT_ROWS_FWD_EN
    test_fwd();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
